// File: rtl/prog_counter.sv
// prog_counter: loadable up/down counter with prescaler, programmable limit,
// wrap/saturate/one-shot/reload terminal modes and a registered terminal-count pulse.
module prog_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  oe,
    output logic [WIDTH-1:0]      count,
    output logic [WIDTH-1:0]      count_oe,
    output logic                  tc,
    output logic                  running
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t                state, state_nx;
    logic [WIDTH-1:0]      reload, count_nx;
    logic [PRESCALE_W-1:0] pre_cnt, pre_nx;
    logic                  tick, term, tc_nx;
    assign count_oe = {WIDTH{oe}};
    assign running  = state == RUN;
    assign tick     = state == RUN && pre_cnt == prescale;
    assign term     = dir ? count == limit : count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            pre_cnt <= pre_nx;
            tc      <= tc_nx;
            if (load) reload <= load_val;
        end
    end
    always_comb begin
        state_nx = state;
        count_nx = count;
        pre_nx   = pre_cnt;
        tc_nx    = 1'b0;
        if (load) begin
            count_nx = load_val;
            pre_nx   = '0;
            state_nx = en ? RUN : IDLE;
        end else begin
            if (state == IDLE && en) state_nx = RUN;
            if (state == RUN && !en) state_nx = IDLE;
            if (state == RUN) pre_nx = tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                tc_nx = term;
                if (!term) count_nx = dir ? count + 1'b1 : count - 1'b1;
                else count_nx = mode == 2'b00 ? (dir ? '0 : limit) :
                                mode == 2'b11 ? reload : count;
                // a finished one-shot halts even if en dropped on the same cycle
                if (term && mode == 2'b10) state_nx = HALT;
            end
        end
    end
endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised, loadable up/down counter with prescaler, programmable limit, four terminal-count modes and a terminal-count pulse. It is the next-generation counter for the user-project tiles. It replaces the fixed 8-bit loadable incrementer and adds direction, rate control, wrap/saturate/one-shot/reload behaviour and an output-enable vector for bidirectional pads. It sits between the pad-level input decode and the bidirectional output bus.

## Interface
Parameters:
- WIDTH, 8: counter width in bits (2..32).
- PRESCALE_W, 4: prescaler compare width in bits (1..16).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  count enable; a level signal that drives the IDLE/RUN state.
- load  in  1  synchronous load strobe; highest priority.
- load_val  in  WIDTH  value for count and for the reload register.
- dir  in  1  direction: 1 = up, 0 = down.
- mode  in  2  terminal behaviour: 00 wrap, 01 saturate, 10 one-shot, 11 reload.
- limit  in  WIDTH  terminal value when counting up; start-over value when wrapping down.
- prescale  in  PRESCALE_W  tick divisor minus one; 0 means a tick every cycle.
- oe  in  1  output enable for the pad bus.
- count  out  WIDTH  current counter value, always driven.
- count_oe  out  WIDTH  {WIDTH{oe}}, combinational.
- tc  out  1  registered one-cycle terminal-count pulse.
- running  out  1  high when the state is RUN.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - HALT: one-shot finished.
- State transitions, with load taking precedence over all of them:
  - IDLE to RUN when en=1.
  - RUN to IDLE when en=0.
  - RUN to HALT on a terminal tick in mode 10.
  - HALT is left only by load. The next state after load is RUN if en=1, otherwise IDLE.
- Prescaler (pre_cnt, PRESCALE_W bits) advances only in RUN.
  - tick = RUN && pre_cnt==prescale.
  - On tick, pre_cnt returns to 0; otherwise pre_cnt increments.
  - In IDLE or HALT, pre_cnt holds.
- Terminal condition:
  - dir=1: count==limit.
  - dir=0: count==0.
- On a tick that is not terminal: count increments by 1 (dir=1) or decrements by 1 (dir=0), modulo 2^WIDTH. A count above limit while counting up therefore rolls through 2^WIDTH-1 and 0, then reaches limit.
- On a terminal tick:
  - Mode 00: up goes to 0, down goes to limit.
  - Mode 01: count holds.
  - Mode 10: count holds and the state goes to HALT.
  - Mode 11: count takes the reload register value.
- load, in any state:
  - count <= load_val.
  - reload register <= load_val.
  - pre_cnt <= 0.
  - tc <= 0.
  - Any tick in the same cycle is discarded.
- tc is set for exactly one cycle after each terminal tick, in every mode. In mode 01, tc therefore repeats on every tick while the count is held.
- dir, mode, limit and prescale are sampled live; a change applies at the next evaluated tick.
- If prescale is lowered below the current pre_cnt, pre_cnt increments and wraps modulo 2^PRESCALE_W before matching.
- oe does not gate load or counting; it drives count_oe only.
- Reset values:
  - count = 0, reload register = 0, pre_cnt = 0.
  - state = IDLE, so running = 0.
  - tc = 0.
  - count_oe follows oe.

## Timing
- en rising with the state sampled at edge k: RUN from edge k. With prescale=P, the first count change is at edge k+1+P, then every P+1 cycles.
- Load latency is one edge: count equals load_val at the edge that sampled load=1.
- The tc flop updates on the same edge as the terminal tick's count update. tc is high from that edge until the next edge.
- Entry to HALT is simultaneous with the terminal-tick update; running drops on that edge.
- Reset asserted mid-run forces all reset values immediately and asynchronously. The first edge after deassertion can already move IDLE to RUN if en=1.
- When load and en-low occur in the same cycle, load applies and the next state is IDLE.

## Test plan
- Reset, then en=1, dir=1, mode=00, limit=5, prescale=0: count runs 1,2,3,4,5,0,1. tc is high the cycle that count shows 0. running=1 throughout.
- Count up with prescale=3, limit=2, mode=00: count changes every 4 cycles, the first change 4 edges after RUN entry. tc pulses once per wrap.
- load_val=3, dir=0, mode=10, en=1: count runs 2,1,0 then holds at 0. The state goes to HALT, running=0, and a single tc pulse occurs. A later load of 7 restarts counting to 6,5,…
- Mode 11, load_val=4, dir=0: count runs 3,2,1,0 then reloads 4, and tc pulses at each reload. In the same run, assert load with load_val=9 on a terminal tick cycle: count=9 and tc=0.
- Mode 01, limit=255, WIDTH=8, load_val=254: count goes to 255 and holds, with tc pulsing on every tick. oe toggled gives count_oe=0xFF or 0x00 with no effect on count. Assert rst_n low mid-count: count=0 and tc=0 immediately.
